// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: PC register, 2-bit BHT, static-target prediction
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BHT_IDX_W = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  input  logic                 bht_upd_en,
  input  logic [BHT_IDX_W-1:0] bht_upd_idx,
  input  logic                 bht_upd_taken,
  output logic [31:0]          imem_addr,
  input  logic [31:0]          imem_rdata,
  output logic [31:0]          if_pc,
  output logic [31:0]          if_instr,
  output logic                 if_pred_taken,
  output logic [BHT_IDX_W-1:0] if_bht_idx
);

  localparam int BHT_N = 1 << BHT_IDX_W;

  logic [31:0]          pc;
  logic [31:0]          pc_next;
  logic [1:0]           bht [BHT_N];
  logic [6:0]           opcode;
  logic                 is_btype;
  logic                 is_jal;
  logic [31:0]          imm_b;
  logic [31:0]          imm_j;
  logic [31:0]          target;
  logic [BHT_IDX_W-1:0] idx;

  assign opcode   = imem_rdata[6:0];
  assign is_btype = (opcode == 7'b1100011);
  assign is_jal   = (opcode == 7'b1101111);

  assign imm_b = {{19{imem_rdata[31]}}, imem_rdata[31], imem_rdata[7],
                  imem_rdata[30:25], imem_rdata[11:8], 1'b0};
  assign imm_j = {{11{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                  imem_rdata[20], imem_rdata[30:21], 1'b0};
  assign target = pc + (is_jal ? imm_j : imm_b);

  assign idx           = pc[BHT_IDX_W+1:2];
  assign if_pred_taken = is_jal | (is_btype & bht[idx][1]);

  assign imem_addr  = pc;
  assign if_pc      = pc;
  assign if_instr   = imem_rdata;
  assign if_bht_idx = idx;

  always_comb begin
    pc_next = pc + 32'd4;
    if (redirect)
      pc_next = redirect_pc;
    else if (stall)
      pc_next = pc;
    else if (if_pred_taken)
      pc_next = target;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pc <= RESET_PC;
    else
      pc <= pc_next;
  end

  // Counters saturate at 00/11; prediction this cycle sees the pre-update value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_N; i++)
        bht[i] <= 2'b01;
    end else if (bht_upd_en) begin
      if (bht_upd_taken) begin
        if (bht[bht_upd_idx] != 2'b11)
          bht[bht_upd_idx] <= bht[bht_upd_idx] + 2'b01;
      end else begin
        if (bht[bht_upd_idx] != 2'b00)
          bht[bht_upd_idx] <= bht[bht_upd_idx] - 2'b01;
      end
    end
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage that produces the inputs of the IF/ID pipeline register: PC, instruction word, predicted-taken flag and BHT index. Holds the PC register and a 128-entry table of 2-bit saturating branch counters (BHT). Computes the next PC from EX redirects, stalls and static-target prediction. Trains the BHT from EX resolution.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
BHT_IDX_W, 7, BHT index width; table has 2**BHT_IDX_W entries, index = pc[BHT_IDX_W+1:2].

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
stall  input  1  hold PC (hazard unit; same cycle IF/ID enable is low).
redirect  input  1  EX mispredict/flush; load redirect_pc.
redirect_pc  input  32  corrected PC from EX.
bht_upd_en  input  1  EX resolved a conditional branch this cycle.
bht_upd_idx  input  BHT_IDX_W  BHT index carried down the pipe.
bht_upd_taken  input  1  actual branch outcome.
imem_addr  output  32  instruction memory address (= PC).
imem_rdata  input  32  instruction word, combinational read of imem_addr.
if_pc  output  32  PC of fetched instruction -> IF/ID.
if_instr  output  32  = imem_rdata -> IF/ID.
if_pred_taken  output  1  prediction -> IF/ID.
if_bht_idx  output  BHT_IDX_W  = pc[BHT_IDX_W+1:2] -> IF/ID.

Behaviour:
- Reset: async on rst high. PC=RESET_PC. Every BHT counter=2'b01 (weakly not-taken). Outputs follow from PC, so imem_addr=if_pc=RESET_PC and if_bht_idx=0 while reset is held.
- imem_addr, if_pc, if_instr, if_bht_idx and if_pred_taken are combinational from the PC register, imem_rdata and the BHT. There is no internal output register; the IF/ID register supplies the stage latency.
- Pre-decode of imem_rdata:
  - B-type (opcode 7'b1100011): imm = sext({i[31],i[7],i[30:25],i[11:8],1'b0}).
  - JAL (7'b1101111): imm = sext({i[31],i[19:12],i[20],i[30:21],1'b0}).
  - target = pc + imm, modulo 2^32.
- Prediction:
  - JAL: taken=1.
  - B-type: taken = BHT[idx][1].
  - All others, including JALR: taken=0.
- Next PC, first match wins:
  1. redirect -> redirect_pc.
  2. stall -> hold PC.
  3. if_pred_taken -> target.
  4. Otherwise pc+4, wrapping 32'hFFFF_FFFC -> 0.
- Redirect overrides stall in the same cycle.
- BHT update, on rising edge when bht_upd_en=1, independent of stall and redirect:
  - taken: counter = min(counter+1, 3).
  - not taken: counter = max(counter-1, 0).
  - Saturates at 2'b00 and 2'b11; no wrap.
- Same index read and updated in the same cycle: prediction uses the pre-update value; the new value is visible next cycle.
- The BHT is not cleared by redirect; only rst clears it.
- Reset asserted mid-operation: PC and BHT return to reset values immediately, without waiting for a clock edge. Updates in flight that cycle are dropped.
- No internal FSM beyond the PC register and BHT. No X propagation: imem_rdata with an unknown opcode is treated as not-branch.

Test Plan:
1. Reset release, imem returns NOPs (32'h0000_0013) -> imem_addr goes 0x0, 0x4, 0x8, 0xC on successive edges; if_pred_taken=0; if_bht_idx=0,1,2,3.
2. JAL x0,+16 (32'h0100_006F) fetched at 0x8 -> if_pred_taken=1; next PC=0x18. JAL imm=-8 at 0x18 -> next PC=0x10.
3. BEQ +32 at 0x20 (idx 8), counter 01 -> predicted not-taken, next 0x24. Apply two bht_upd_taken=1 at idx 8 -> counter 11; refetch 0x20 -> taken, next 0x40. One not-taken update -> 10, still taken. Updates at 11 stay 11; updates at 00 stay 00.
4. stall=1 for 3 cycles at PC 0x30 -> PC held at 0x30 all cycles, BHT update applied meanwhile. stall=1 with redirect=1, redirect_pc=0x100 -> next PC=0x100.
5. Same-cycle read and update: fetch BEQ at idx 5 (counter 01) while bht_upd_en=1, idx 5, taken=1 -> prediction 0 this cycle; counter 10 next cycle.
6. Assert rst asynchronously between edges at PC 0x200 with trained BHT -> imem_addr=0x0 immediately; all counters read 01 after release. PC wrap: redirect to 32'hFFFF_FFFC with a NOP -> next PC=0x0.
